proc_run_ctrl: RTL and testbench
================================

# proc_run_ctrl

Run/step controller that sequences the TinyRV1 processor in simulation and FPGA test harnesses. It gates the processor enable from start, single-step, pause and clear commands. It counts active cycles until the program signals completion and retired instructions. It forces a halt when a cycle budget is exhausted. It sits between the harness (or switch/button debouncers) and the processor's enable input, and consumes the processor's trace-valid and done indications.

## Interface

- MAX_CYCLES, 500: cycle budget; reaching it forces TIMEOUT.
- CW, 32: width of cycle_count and inst_count.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- go  in  1  pulse: start continuous run.
- step  in  1  pulse: execute exactly one instruction.
- stop  in  1  pulse: pause continuous run.
- clear  in  1  pulse: leave DONE/TIMEOUT/IDLE and zero counters.
- done  in  1  level from processor (out1 != 0): program finished.
- trace_val  in  1  processor retired an instruction this cycle.
- proc_en  out  1  processor may advance this cycle.
- state  out  3  IDLE=0, RUN=1, STEP=2, DONE=3, TIMEOUT=4.
- finished  out  1  state is DONE or TIMEOUT.
- timeout  out  1  state is TIMEOUT.
- cycle_count  out  CW  enabled cycles with done==0.
- inst_count  out  CW  enabled cycles with trace_val==1.

## Operation

- Moore outputs: proc_en = (state==RUN || state==STEP); finished and timeout are decoded from state only.
- Reset (async, any time, including mid-run): state=IDLE, proc_en=0, finished=0, timeout=0, cycle_count=0, inst_count=0.
- Priority is evaluated each edge. In all states, clear has top priority: next state IDLE, both counters 0.
- IDLE: if go, go to RUN (go beats step). Else if step, go to STEP. stop is ignored.
- RUN:
  - done=1: go to DONE.
  - Else if the increment makes cycle_count==MAX_CYCLES: go to TIMEOUT.
  - Else if stop: go to IDLE.
  - Else stay in RUN. go and step are ignored.
- STEP:
  - done=1: go to DONE.
  - Else if timeout is reached: go to TIMEOUT.
  - Else if trace_val or stop: go to IDLE.
  - Else stay in STEP, waiting for retirement.
- DONE, TIMEOUT: sticky. go, step and stop are ignored. Only clear or rst exits.
- Counter rules (apply only while proc_en=1):
  - cycle_count += 1 when done==0.
  - inst_count += 1 when trace_val==1.
  - Both counters hold in IDLE, DONE and TIMEOUT.
  - Counters never wrap. The timeout check compares against MAX_CYCLES before any overflow. MAX_CYCLES < 2^CW is required.
- done and timeout in the same cycle: done wins, giving DONE. cycle_count does not increment because done==1.
- Unencoded state values (5–7) recover to IDLE on the next edge.

## Timing

- Command-to-enable latency is 1 cycle: go sampled at edge N gives proc_en=1 in cycle N+1.
- done sampled high at edge N (while enabled) gives proc_en=0 from cycle N+1. The processor has already been enabled during cycle N; that cycle counts toward inst_count if trace_val=1, but not toward cycle_count.
- stop sampled at edge N drops proc_en in cycle N+1. Exactly the cycles between the go edge and the stop edge are enabled.
- Single step with a 1-cycle-retire processor: step at edge N, proc_en=1 in cycle N+1, trace_val=1, IDLE at edge N+1. Exactly one enabled cycle per step.
- Counters and state update on the same edge. Outputs are valid after clk-to-q, with no combinational path from inputs to outputs.

## Test plan

- Reset mid-RUN: assert rst asynchronously at cycle 7 of a run → state=0, proc_en=0 and both counts 0 immediately, without waiting for a clock edge.
- Continuous run: go, trace_val=1 every cycle, done rises after 20 enabled cycles → state=DONE, cycle_count=20, inst_count=21, proc_en=0 thereafter; a later go has no effect.
- Timeout: MAX_CYCLES=8, go, done held 0 → proc_en high exactly 8 cycles, state=TIMEOUT, cycle_count=8, timeout=1. Then clear → IDLE with counts 0.
- Stepping: three step pulses spaced 4 cycles apart, trace_val=1 whenever enabled → three single-cycle proc_en pulses, inst_count=3, state returns to IDLE each time.
- Simultaneous events:
  - go+step in IDLE gives RUN.
  - done and the timeout boundary on the same edge give DONE with cycle_count=MAX_CYCLES-1.
  - stop+done in RUN gives DONE.
- Pause/resume: go, stop after 5 enabled cycles, idle 10 cycles, go, done after 3 more → cycle_count=8; counts hold during the pause.

Source files
------------

// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: run/step controller for the TinyRV1 processor.
// Gates proc_en from go/step/stop/clear commands, counts enabled cycles and
// retired instructions, and forces TIMEOUT when the cycle budget runs out.
module proc_run_ctrl #(
    parameter int MAX_CYCLES = 500,
    parameter int CW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          step,
    input  logic          stop,
    input  logic          clear,
    input  logic          done,
    input  logic          trace_val,
    output logic          proc_en,
    output logic [2:0]    state,
    output logic          finished,
    output logic          timeout,
    output logic [CW-1:0] cycle_count,
    output logic [CW-1:0] inst_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_STEP    = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    localparam logic [CW-1:0] MAX_C = CW'(MAX_CYCLES);
    localparam logic [CW-1:0] ONE   = CW'(1);

    state_t state_q;
    state_t state_d;
    logic   cyc_inc;
    logic   inst_inc;
    logic   at_limit;

    // Moore outputs decoded from the registered state only.
    assign state    = state_q;
    assign proc_en  = (state_q == S_RUN) || (state_q == S_STEP);
    assign finished = (state_q == S_DONE) || (state_q == S_TIMEOUT);
    assign timeout  = (state_q == S_TIMEOUT);

    // Counter enables; the all-ones guard keeps the counters from wrapping.
    assign cyc_inc  = proc_en && !done && (cycle_count != '1);
    assign inst_inc = proc_en && trace_val && (inst_count != '1);
    // This edge's increment lands exactly on the budget.
    assign at_limit = cyc_inc && ((cycle_count + ONE) == MAX_C);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: clear first, then per-state priorities.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go)        state_d = S_RUN;
                    else if (step) state_d = S_STEP;
                end
                S_RUN: begin
                    if (done)          state_d = S_DONE;
                    else if (at_limit) state_d = S_TIMEOUT;
                    else if (stop)     state_d = S_IDLE;
                end
                S_STEP: begin
                    if (done)                   state_d = S_DONE;
                    else if (at_limit)          state_d = S_TIMEOUT;
                    else if (trace_val || stop) state_d = S_IDLE;
                end
                S_DONE:    state_d = S_DONE;
                S_TIMEOUT: state_d = S_TIMEOUT;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Cycle and instruction counters; they only move while proc_en is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= '0;
            inst_count  <= '0;
        end else if (clear) begin
            cycle_count <= '0;
            inst_count  <= '0;
        end else begin
            if (cyc_inc)  cycle_count <= cycle_count + ONE;
            if (inst_inc) inst_count  <= inst_count + ONE;
        end
    end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb_proc_run_ctrl: directed bench for proc_run_ctrl. Two instances share the
// stimulus: dut uses the default budget, dut8 a budget of 8 cycles.
module tb_proc_run_ctrl;

    logic        clk = 1'b0;
    logic        rst, go, step, stop, clear, done, trace_val;
    logic        en_a, fin_a, to_a, en_b, fin_b, to_b;
    logic [2:0]  st_a, st_b;
    logic [31:0] cyc_a, ins_a, cyc_b, ins_b;
    int          checks = 0;
    int          failures = 0;
    int          pulses;
    int          en_cycles;

    always #5 clk = ~clk;

    proc_run_ctrl dut (
        .clk(clk), .rst(rst), .go(go), .step(step), .stop(stop), .clear(clear),
        .done(done), .trace_val(trace_val), .proc_en(en_a), .state(st_a),
        .finished(fin_a), .timeout(to_a), .cycle_count(cyc_a), .inst_count(ins_a)
    );

    proc_run_ctrl #(.MAX_CYCLES(8), .CW(32)) dut8 (
        .clk(clk), .rst(rst), .go(go), .step(step), .stop(stop), .clear(clear),
        .done(done), .trace_val(trace_val), .proc_en(en_b), .state(st_b),
        .finished(fin_b), .timeout(to_b), .cycle_count(cyc_b), .inst_count(ins_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs settle and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go();    go = 1'b1;    tick(); go = 1'b0;    endtask
    task automatic pulse_stop();  stop = 1'b1;  tick(); stop = 1'b0;  endtask
    task automatic pulse_step();  step = 1'b1;  tick(); step = 1'b0;  endtask
    task automatic pulse_clear(); clear = 1'b1; tick(); clear = 1'b0; endtask

    initial begin
        {go, step, stop, clear, done, trace_val} = '0;
        rst = 1'b1;
        #12 rst = 1'b0;
        tick();

        // Reset values
        check("rst_state", 32'(st_a), 0);
        check("rst_en",    32'(en_a), 0);
        check("rst_fin",   32'({fin_a, to_a}), 0);
        check("rst_cyc",   cyc_a, 0);

        // Async reset in the 7th enabled cycle of a run
        trace_val = 1'b1;
        pulse_go();
        repeat (6) tick();
        check("mid_run_cyc", cyc_a, 6);
        #2 rst = 1'b1;
        #1;
        check("arst_state", 32'(st_a), 0);
        check("arst_en",    32'(en_a), 0);
        check("arst_cyc",   cyc_a, 0);
        check("arst_ins",   ins_a, 0);
        rst = 1'b0;
        tick();

        // Continuous run: done on the 21st enabled cycle
        pulse_go();
        check("run_en", 32'(en_a), 1);
        repeat (20) tick();
        done = 1'b1;
        tick();
        check("run_state", 32'(st_a), 3);
        check("run_cyc",   cyc_a, 20);
        check("run_ins",   ins_a, 21);
        check("run_en_off", 32'(en_a), 0);
        check("run_fin",   32'(fin_a), 1);
        done = 1'b0;
        pulse_go();
        tick();
        check("done_sticky", 32'(st_a), 3);
        check("done_hold",   cyc_a, 20);

        // Timeout on the 8-cycle instance, then clear
        pulse_clear();
        check("clr_state", 32'(st_b), 0);
        trace_val = 1'b0;
        pulse_go();
        en_cycles = 0;
        for (int i = 0; i < 20 && en_b; i++) begin
            en_cycles++;
            tick();
        end
        check("to_en_cycles", 32'(en_cycles), 8);
        check("to_state",     32'(st_b), 4);
        check("to_cyc",       cyc_b, 8);
        check("to_flag",      32'({fin_b, to_b}), 3);
        pulse_step();
        check("to_sticky", 32'(st_b), 4);
        pulse_clear();
        check("to_clr_state", 32'(st_b), 0);
        check("to_clr_cyc",   cyc_b, 0);

        // Three single steps spaced 4 cycles apart
        trace_val = 1'b1;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            pulse_step();
            check("step_state", 32'(st_a), 2);
            pulses += int'(en_a);
            tick();
            check("step_idle", 32'(st_a), 0);
            pulses += int'(en_a);
            tick();
            tick();
        end
        check("step_pulses", 32'(pulses), 3);
        check("step_ins",    ins_a, 3);
        check("step_cyc",    cyc_a, 3);

        // go + step together in IDLE
        pulse_clear();
        go = 1'b1; step = 1'b1;
        tick();
        go = 1'b0; step = 1'b0;
        check("go_step", 32'(st_a), 1);

        // done on the same edge as the budget boundary (8-cycle instance)
        pulse_clear();
        pulse_go();
        repeat (7) tick();
        check("bnd_pre", cyc_b, 7);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("bnd_state", 32'(st_b), 3);
        check("bnd_cyc",   cyc_b, 7);
        check("bnd_to",    32'(to_b), 0);

        // stop + done in RUN
        pulse_clear();
        pulse_go();
        tick(); tick();
        stop = 1'b1; done = 1'b1;
        tick();
        stop = 1'b0; done = 1'b0;
        check("stop_done", 32'(st_a), 3);

        // Pause/resume
        pulse_clear();
        trace_val = 1'b0;
        pulse_go();
        repeat (4) tick();
        pulse_stop();
        check("pause_state", 32'(st_a), 0);
        check("pause_cyc",   cyc_a, 5);
        repeat (10) tick();
        check("pause_hold",  cyc_a, 5);
        pulse_go();
        repeat (3) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("resume_state", 32'(st_a), 3);
        check("resume_cyc",   cyc_a, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
